// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer slice.
package pc_pkg;

  localparam int unsigned PC_WIDTH_DEF     = 7;
  localparam int unsigned OFFSET_WIDTH_DEF = 5;
  localparam int unsigned STACK_DEPTH_DEF  = 4;

  typedef enum logic [2:0] {
    PC_HOLD   = 3'd0,
    PC_INC    = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JUMP   = 3'd3,
    PC_CALL   = 3'd4,
    PC_RET    = 3'd5
  } pc_op_t;

  // Fixed-priority selection: hold beats return beats call beats jump beats branch.
  function automatic pc_op_t decode_op(
    input logic hold,
    input logic ret,
    input logic call,
    input logic jump,
    input logic branch
  );
    pc_op_t op;
    if (hold == 1'b1) begin
      op = PC_HOLD;
    end else if (ret == 1'b1) begin
      op = PC_RET;
    end else if (call == 1'b1) begin
      op = PC_CALL;
    end else if (jump == 1'b1) begin
      op = PC_JUMP;
    end else if (branch == 1'b1) begin
      op = PC_BRANCH;
    end else begin
      op = PC_INC;
    end
    return op;
  endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. Only the occupancy count is reset; entries at or
// above the count are never read, so the storage itself needs no reset.
module return_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF,
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic                         Clock,
  input  logic                         nReset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    count_q;
  logic [IW-1:0]    wr_idx_s;
  logic [IW-1:0]    rd_idx_s;
  logic             do_push_s;
  logic             do_pop_s;

  // Occupancy flags, guarded push/pop and next count; pop wins if both are asked.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == {CW{1'b0}});
    do_pop_s  = pop & ~empty;
    do_push_s = push & ~full & ~pop;
    wr_idx_s  = IW'(count_q);
    rd_idx_s  = IW'(count_q - CW'(1));
    dout      = mem_q[rd_idx_s];
    if (do_push_s) begin
      count_d = count_q + CW'(1);
    end else if (do_pop_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Occupancy register; reset empties the stack logically.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge Clock) begin
    if (do_push_s) begin
      mem_q[wr_idx_s] <= din;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, relative branch, absolute jump and
// call/return through a bounded return-address stack with sticky error flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_WIDTH     = PC_WIDTH_DEF,
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int STACK_DEPTH  = STACK_DEPTH_DEF
) (
  input  logic                               Clock,
  input  logic                               nReset,
  input  logic                               PCHold,
  input  logic                               Branch,
  input  logic [OFFSET_WIDTH-1:0]            BranchOffset,
  input  logic                               Jump,
  input  logic                               Call,
  input  logic                               Return,
  input  logic [PC_WIDTH-1:0]                Target,
  input  logic                               ErrClear,
  output logic [PC_WIDTH-1:0]                ProgramCounter,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   StackCount,
  output logic                               StackOverflow,
  output logic                               StackUnderflow
);

  pc_op_t              op_s;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_inc_s;
  logic [PC_WIDTH-1:0] offset_ext_s;
  logic [PC_WIDTH-1:0] stk_dout_s;
  logic                ovf_q;
  logic                ovf_d;
  logic                unf_q;
  logic                unf_d;
  logic                push_s;
  logic                pop_s;
  logic                stk_full_s;
  logic                stk_empty_s;

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .Clock  (Clock),
    .nReset (nReset),
    .push   (push_s),
    .pop    (pop_s),
    .din    (pc_inc_s),
    .dout   (stk_dout_s),
    .count  (StackCount),
    .full   (stk_full_s),
    .empty  (stk_empty_s)
  );

  // Operation decode, next-PC mux, stack requests and sticky flag update.
  always_comb begin
    op_s         = decode_op(PCHold, Return, Call, Jump, Branch);
    pc_inc_s     = pc_q + PC_WIDTH'(1);
    offset_ext_s = PC_WIDTH'($signed(BranchOffset));
    push_s       = 1'b0;
    pop_s        = 1'b0;
    pc_d         = pc_q;
    // Clear first so an error in the same cycle sets the flag again.
    if ((op_s != PC_HOLD) && ErrClear) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
      unf_d = unf_q;
    end
    case (op_s)
      PC_INC:    pc_d = pc_inc_s;
      PC_BRANCH: pc_d = pc_q + offset_ext_s;
      PC_JUMP:   pc_d = Target;
      PC_CALL: begin
        if (stk_full_s) begin
          pc_d  = pc_inc_s;
          ovf_d = 1'b1;
        end else begin
          push_s = 1'b1;
          pc_d   = Target;
        end
      end
      PC_RET: begin
        if (stk_empty_s) begin
          pc_d  = pc_inc_s;
          unf_d = 1'b1;
        end else begin
          pop_s = 1'b1;
          pc_d  = stk_dout_s;
        end
      end
      PC_HOLD:   pc_d = pc_q;
      default:   pc_d = pc_q;
    endcase
  end

  // PC and sticky error flags; reset is immediate and clock-independent.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pc_q  <= {PC_WIDTH{1'b0}};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ProgramCounter = pc_q;
  assign StackOverflow  = ovf_q;
  assign StackUnderflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver issues directed and random
// operations and queues the reference result; a monitor compares after each edge.
module tb_pc_sequencer;

  localparam int PW  = 7;
  localparam int OW  = 5;
  localparam int SD  = 4;
  localparam int SCW = 3;

  logic          Clock;
  logic          nReset;
  logic          PCHold;
  logic          Branch;
  logic [OW-1:0] BranchOffset;
  logic          Jump;
  logic          Call;
  logic          Return;
  logic [PW-1:0] Target;
  logic          ErrClear;
  logic [PW-1:0] ProgramCounter;
  logic [SCW-1:0] StackCount;
  logic          StackOverflow;
  logic          StackUnderflow;

  pc_sequencer #(.PC_WIDTH(PW), .OFFSET_WIDTH(OW), .STACK_DEPTH(SD)) dut (
    .Clock          (Clock),
    .nReset         (nReset),
    .PCHold         (PCHold),
    .Branch         (Branch),
    .BranchOffset   (BranchOffset),
    .Jump           (Jump),
    .Call           (Call),
    .Return         (Return),
    .Target         (Target),
    .ErrClear       (ErrClear),
    .ProgramCounter (ProgramCounter),
    .StackCount     (StackCount),
    .StackOverflow  (StackOverflow),
    .StackUnderflow (StackUnderflow)
  );

  typedef struct {
    int pc;
    int cnt;
    int ovf;
    int unf;
  } exp_t;

  exp_t exp_q[$];
  int   m_pc;
  int   m_stack[$];
  int   m_ovf;
  int   m_unf;
  int   checks = 0;
  int   errors = 0;

  // Free-running clock, period 10.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 0;
    m_stack.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Reference behaviour written directly from the operation rules.
  task automatic model_step(input bit h, input bit b, input int off, input bit j,
                            input bit c, input bit r, input int tgt, input bit ec);
    int so;
    if (h) return;
    if (ec) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (r) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin
        m_pc  = (m_pc + 1) % 128;
        m_unf = 1;
      end
    end else if (c) begin
      if (m_stack.size() < SD) begin
        m_stack.push_back((m_pc + 1) % 128);
        m_pc = tgt;
      end else begin
        m_pc  = (m_pc + 1) % 128;
        m_ovf = 1;
      end
    end else if (j) begin
      m_pc = tgt;
    end else if (b) begin
      so   = (off >= 16) ? off - 32 : off;
      m_pc = ((m_pc + so) % 128 + 128) % 128;
    end else begin
      m_pc = (m_pc + 1) % 128;
    end
  endtask

  task automatic apply(input bit h, input bit b, input logic [OW-1:0] off, input bit j,
                       input bit c, input bit r, input logic [PW-1:0] tgt, input bit ec);
    exp_t e;
    PCHold = h; Branch = b; BranchOffset = off; Jump = j;
    Call = c; Return = r; Target = tgt; ErrClear = ec;
    model_step(h, b, int'(off), j, c, r, int'(tgt), ec);
    e.pc  = m_pc;
    e.cnt = m_stack.size();
    e.ovf = m_ovf;
    e.unf = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit h, input bit b, input logic [OW-1:0] off, input bit j,
                      input bit c, input bit r, input logic [PW-1:0] tgt, input bit ec);
    @(negedge Clock);
    #1;
    apply(h, b, off, j, c, r, tgt, ec);
  endtask

  task automatic inc();                      step(0, 0, 5'd0, 0, 0, 0, 7'd0, 0); endtask
  task automatic hold();                     step(1, 0, 5'd0, 0, 0, 0, 7'd0, 1); endtask
  task automatic jump(input logic [6:0] t);  step(0, 0, 5'd0, 1, 0, 0, t, 0);    endtask
  task automatic branch(input logic [4:0] o); step(0, 1, o, 0, 0, 0, 7'd0, 0);   endtask
  task automatic call(input logic [6:0] t);  step(0, 0, 5'd0, 0, 1, 0, t, 0);    endtask
  task automatic ret();                      step(0, 0, 5'd0, 0, 0, 1, 7'd0, 0); endtask
  task automatic errclr();                   step(0, 0, 5'd0, 0, 0, 0, 7'd0, 1); endtask

  // Mid-cycle reset pulse: outputs must clear before any clock edge.
  task automatic pulse_reset();
    @(negedge Clock);
    #1 nReset = 1'b0;
    #1;
    check("async_rst_pc", 32'(ProgramCounter), 0);
    check("async_rst_cnt", 32'(StackCount), 0);
    check("async_rst_ovf", 32'(StackOverflow), 0);
    check("async_rst_unf", 32'(StackUnderflow), 0);
    #1 nReset = 1'b1;
    model_reset();
    apply(0, 0, 5'd0, 0, 0, 0, 7'd0, 0);
  endtask

  // Monitor: after every rising edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", 32'(ProgramCounter), e.pc);
        check("stack_count", 32'(StackCount), e.cnt);
        check("overflow", 32'(StackOverflow), e.ovf);
        check("underflow", 32'(StackUnderflow), e.unf);
      end
    end
  end

  // Driver: directed scenarios followed by constrained-random traffic.
  initial begin
    nReset = 1'b0; PCHold = 1'b0; Branch = 1'b0; BranchOffset = 5'd0; Jump = 1'b0;
    Call = 1'b0; Return = 1'b0; Target = 7'd0; ErrClear = 1'b0;
    model_reset();
    #12;
    check("rst_pc", 32'(ProgramCounter), 0);
    check("rst_cnt", 32'(StackCount), 0);
    check("rst_ovf", 32'(StackOverflow), 0);
    check("rst_unf", 32'(StackUnderflow), 0);
    @(negedge Clock);
    #1 nReset = 1'b1;
    apply(0, 0, 5'd0, 0, 0, 0, 7'd0, 0);

    // 130 increments total (wrap 127 -> 0), then hold with ErrClear ignored.
    for (int i = 0; i < 129; i++) inc();
    for (int i = 0; i < 3; i++) hold();

    // Relative branches wrapping in both directions.
    jump(7'd3);   branch(5'b11011);
    jump(7'd120); branch(5'd15);

    // Two nested calls and their returns.
    jump(7'd10); call(7'd40); jump(7'd41); call(7'd90); ret(); ret();

    // Overflow on the fifth call, underflow on the fifth return, then clear.
    for (int i = 0; i < 5; i++) call(7'(20 + i * 10));
    for (int i = 0; i < 5; i++) ret();
    errclr();

    // Return beats Call and Jump when all are asserted.
    call(7'd50);
    step(0, 0, 5'd0, 1, 1, 1, 7'd99, 0);

    // Error set and clear in the same cycle: set wins.
    ret();
    step(0, 0, 5'd0, 0, 0, 1, 7'd0, 1);
    errclr();

    // Reset with three pending returns, then a return underflows.
    call(7'd5); call(7'd60); call(7'd100);
    pulse_reset();
    ret();

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(199) == 0) begin
        pulse_reset();
      end else begin
        step($urandom_range(7) == 0, $urandom_range(2) == 0, 5'($urandom),
             $urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(4) == 0,
             7'($urandom), $urandom_range(9) == 0);
      end
    end

    @(posedge Clock);
    #2;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
